// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared default widths and select-width helper for the registered 1-to-N demux
package demux_pkg;

  localparam int DEMUX_DATA_W_DEF     = 8;
  localparam int DEMUX_NUM_OUT_DEF    = 4;
  localparam int DEMUX_DROP_CNT_W_DEF = 8;

  // clog2 that never returns less than 1, so a select port always exists.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// rtl/demux_out_slot.sv - one-entry output slot with valid/ready handshake and pass-through free flag
//   clk, rst       : clock, async active-high reset (empties slot, clears data)
//   load, data_in  : capture data_in into the slot at the next edge
//   y_valid/y_data : slot contents toward the consumer
//   y_ready        : consumer accept
//   free           : slot can take a new beat this cycle (empty, or draining now)
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = DEMUX_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              y_ready,
  output logic              y_valid,
  output logic [DATA_W-1:0] y_data,
  output logic              free
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // A load wins over a drain so a slot emptied and refilled in one cycle stays valid.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = data_in;
    end else if (valid_q && y_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign y_valid = valid_q;
  assign y_data  = data_q;
  assign free    = !valid_q || y_ready;

endmodule

// File: rtl/demux_1ton_reg.sv
// rtl/demux_1ton_reg.sv - registered 1-to-N demux with unicast, broadcast and out-of-range drop counting
//   clk, rst            : clock, async active-high reset
//   in_data/in_valid    : input beat; in_ready accepts it
//   sel, bcast          : target channel / copy-to-all, sampled with the beat
//   y_data/y_valid      : per-channel slot outputs, channel i at [i*DATA_W +: DATA_W]
//   y_ready             : per-channel consumer accept
//   drop_cnt            : saturating count of beats dropped for sel >= NUM_OUT
module demux_1ton_reg
  import demux_pkg::*;
#(
  parameter int  DATA_W     = DEMUX_DATA_W_DEF,
  parameter int  NUM_OUT    = DEMUX_NUM_OUT_DEF,
  parameter int  DROP_CNT_W = DEMUX_DROP_CNT_W_DEF,
  localparam int SEL_W      = clog2_min1(NUM_OUT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      bcast,
  output logic [NUM_OUT*DATA_W-1:0] y_data,
  output logic [NUM_OUT-1:0]        y_valid,
  input  logic [NUM_OUT-1:0]        y_ready,
  output logic [DROP_CNT_W-1:0]     drop_cnt
);

  // One extra bit so NUM_OUT itself is representable when it is a power of two.
  localparam logic [SEL_W:0] NUM_OUT_V = (SEL_W + 1)'(NUM_OUT);

  logic [NUM_OUT-1:0]    sel_hit;
  logic [NUM_OUT-1:0]    free;
  logic [NUM_OUT-1:0]    load;
  logic                  in_range;
  logic                  xfer;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  // One-hot decode; all zeros when sel is out of range.
  always_comb begin
    sel_hit = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      sel_hit[i] = (sel == SEL_W'(i));
    end
  end

  assign in_range = ({1'b0, sel} < NUM_OUT_V);

  // Out-of-range beats are always swallowed so a bad sel cannot stall the producer.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (bcast)         in_ready = &free;
      else if (in_range) in_ready = |(sel_hit & free);
      else               in_ready = 1'b1;
    end
  end

  assign xfer = in_valid && in_ready;
  assign load = !xfer ? '0 : (bcast ? '1 : sel_hit);

  always_comb begin
    drop_d = drop_q;
    if (xfer && !bcast && !in_range && (drop_q != {DROP_CNT_W{1'b1}})) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
    demux_out_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (load[g]),
      .data_in (in_data),
      .y_ready (y_ready[g]),
      .y_valid (y_valid[g]),
      .y_data  (y_data[g*DATA_W +: DATA_W]),
      .free    (free[g])
    );
  end

endmodule

// File: tb/tb_demux_1ton_reg.sv
// tb/tb_demux_1ton_reg.sv - self-checking bench for demux_1ton_reg (4-channel and 3-channel instances)
module tb_demux_1ton_reg;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int N3 = 3;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0]   in_data;
  logic            in_valid, in_ready, bcast;
  logic [1:0]      sel;
  logic [N*DW-1:0] y_data;
  logic [N-1:0]    y_valid, y_ready;
  logic [CW-1:0]   drop_cnt;

  logic [DW-1:0]    in_data3;
  logic             in_valid3, in_ready3, bcast3;
  logic [1:0]       sel3;
  logic [N3*DW-1:0] y_data3;
  logic [N3-1:0]    y_valid3, y_ready3;
  logic [CW-1:0]    drop_cnt3;

  demux_1ton_reg #(.DATA_W(DW), .NUM_OUT(N), .DROP_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .bcast(bcast), .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
    .drop_cnt(drop_cnt)
  );

  demux_1ton_reg #(.DATA_W(DW), .NUM_OUT(N3), .DROP_CNT_W(CW)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .sel(sel3), .bcast(bcast3), .y_data(y_data3), .y_valid(y_valid3), .y_ready(y_ready3),
    .drop_cnt(drop_cnt3)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the 4-channel instance: what each consumer should currently see.
  logic          mv [N];
  logic [DW-1:0] md [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ready();
    if (rst) return 1'b0;
    if (bcast) begin
      for (int i = 0; i < N; i++) if (mv[i] && !y_ready[i]) return 1'b0;
      return 1'b1;
    end
    if (int'(sel) < N) return !mv[sel] || y_ready[sel];
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
  endtask

  task automatic check_state(input string tag);
    logic [N-1:0] ev;
    for (int i = 0; i < N; i++) begin
      ev[i] = mv[i];
      chk({tag, "_data"}, y_data[i*DW +: DW], md[i]);
    end
    chk({tag, "_valid"}, y_valid, ev);
    chk({tag, "_drop"}, drop_cnt, 0);
  endtask

  // Inputs are set by the caller at posedge+1; this checks in_ready, crosses one edge, checks state.
  task automatic step(input string tag);
    logic          er, acc, b;
    logic [DW-1:0] d;
    logic [1:0]    s;
    logic [N-1:0]  r;
    #1;
    er = exp_ready();
    chk({tag, "_in_ready"}, in_ready, er);
    acc = in_valid && er;
    d = in_data; b = bcast; s = sel; r = y_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc && (b || int'(s) == i)) begin
        mv[i] = 1'b1;
        md[i] = d;
      end else if (mv[i] && r[i]) begin
        mv[i] = 1'b0;
      end
    end
    check_state(tag);
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0; in_valid = 1'b0; sel = '0; bcast = 1'b0; y_ready = '0;
    in_data3 = '0; in_valid3 = 1'b0; sel3 = '0; bcast3 = 1'b0; y_ready3 = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    check_state("rst");
    chk("rst3_valid", y_valid3, 0);
    chk("rst3_drop", drop_cnt3, 0);
    rst = 1'b0;

    // Out-of-range drops on the 3-channel instance, saturating at 255.
    sel3 = 2'd3; in_valid3 = 1'b1;
    for (int k = 0; k < 300; k++) begin
      in_data3 = 8'($urandom);
      #1;
      chk("oor_in_ready", in_ready3, 1);
      @(posedge clk);
      #1;
      chk("oor_valid", y_valid3, 0);
      chk("oor_drop", drop_cnt3, (k + 1 > 255) ? 255 : k + 1);
    end
    in_valid3 = 1'b0;

    // Back-to-back unicast with all consumers ready.
    y_ready = 4'b1111; in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data = 8'(k + 1);
      sel = 2'(k % 4);
      #1;
      chk("b2b_ready_hi", in_ready, 1);
      step("b2b");
    end
    in_valid = 1'b0;
    step("b2b_drain");

    // Backpressure on channel 1.
    y_ready = 4'b0000; in_valid = 1'b1; sel = 2'd1;
    in_data = 8'h11; step("bp_first");
    in_data = 8'h22; step("bp_held");
    step("bp_held2");
    chk("bp_y1_hold", y_data[15:8], 8'h11);
    y_ready[1] = 1'b1; step("bp_release");
    chk("bp_y1_new", y_data[15:8], 8'h22);

    // Broadcast blocked by a stalled slot 3, then released.
    y_ready = 4'b0000; sel = 2'd3; in_data = 8'h77; step("bc_fill3");
    y_ready = 4'b0111; bcast = 1'b1; in_data = 8'h3C; step("bc_blocked");
    y_ready = 4'b1111; step("bc_go");
    chk("bc_all_valid", y_valid, 4'b1111);
    chk("bc_all_data", y_data, 32'h3C3C3C3C);

    // Independence: drain 0 and 2 while reloading 0.
    bcast = 1'b0; y_ready = 4'b0000; in_valid = 1'b0; step("ind_hold");
    y_ready = 4'b0101; in_valid = 1'b1; sel = 2'd0; in_data = 8'h5A; step("ind");
    chk("ind_valid", y_valid, 4'b1011);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      in_valid = 1'($urandom);
      sel      = 2'($urandom);
      bcast    = ($urandom_range(0, 4) == 0);
      y_ready  = 4'($urandom);
      in_data  = 8'($urandom);
      step("rand");
    end

    // Reset mid-stream with channels 1 and 3 full.
    in_valid = 1'b0; bcast = 1'b0; y_ready = 4'b1111; step("pre_rst_drain");
    y_ready = 4'b0000; in_valid = 1'b1;
    sel = 2'd1; in_data = 8'h31; step("pre_rst_c1");
    sel = 2'd3; in_data = 8'h33; step("pre_rst_c3");
    chk("pre_rst_valid", y_valid, 4'b1010);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    chk("arst_in_ready", in_ready, 0);
    check_state("arst");
    chk("arst3_drop", drop_cnt3, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_data = 8'hA5; sel = 2'd2; in_valid = 1'b1;
    step("post_rst");
    chk("post_rst_valid", y_valid, 4'b0100);
    chk("post_rst_data", y_data[23:16], 8'hA5);
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1ton_reg.md
Name: demux_1toN_reg

Overview:
- Parametrised, registered 1-to-N demultiplexer with a valid/ready handshake on the input and on every output channel.
- Each input beat is steered to the channel named by `sel`, or copied to all channels in broadcast mode.
- Each channel holds the beat in a one-entry output slot until the downstream consumer accepts it.
- Sits between a single producer and N consumers in the datapath; successor to the gate-level 1x2 demux.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- NUM_OUT, 4, number of output channels (2..16; need not be a power of two).
- SEL_W, clog2(NUM_OUT) (minimum 1), width of `sel`; derived, not overridden.
- DROP_CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  DATA_W  input payload.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- sel  input  SEL_W  target channel; sampled with the beat.
- bcast  input  1  1 = copy the beat to all channels; sampled with the beat.
- y_data  output  NUM_OUT*DATA_W  channel i payload at bits [i*DATA_W +: DATA_W].
- y_valid  output  NUM_OUT  per-channel slot full.
- y_ready  input  NUM_OUT  per-channel consumer accept.
- drop_cnt  output  DROP_CNT_W  count of beats dropped for an out-of-range `sel`.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - all y_valid = 0, y_data = 0, drop_cnt = 0.
  - in_ready = 0 while rst is high.
- Input transfer occurs on in_valid & in_ready.
- Output transfer on channel i occurs on y_valid[i] & y_ready[i]; this clears slot i at the next edge unless the slot is refilled in the same cycle.
- Slot i is "free" when y_valid[i] = 0, or when y_valid[i] & y_ready[i] (pass-through allowed, so full throughput is possible).
- Unicast (bcast = 0, sel < NUM_OUT):
  - in_ready = free[sel].
  - On transfer: slot[sel] <= in_data and y_valid[sel] <= 1 at the next edge. Latency is 1 cycle.
- Broadcast (bcast = 1):
  - in_ready = AND of free[i] over all i.
  - On transfer: every slot is loaded with in_data and every y_valid is set at the next edge.
  - `sel` is ignored.
- Out of range (bcast = 0, sel >= NUM_OUT; only possible when NUM_OUT is not a power of two):
  - in_ready = 1 and the beat is consumed.
  - No slot changes.
  - drop_cnt increments by 1, saturating at all-ones.
- in_ready is purely combinational from sel, bcast, y_valid and y_ready. It does not depend on in_valid (no combinational loop through in_valid).
- Channel isolation: slots not targeted by a transfer keep their data and valid. Simultaneous drains on any set of channels are independent.
- y_data[i] is stable while y_valid[i] & !y_ready[i] (no overwrite of a stalled slot).
- Reset mid-operation: all slots are emptied immediately and any in-flight beat is lost. After rst deasserts, the first beat is accepted on the first edge at which in_valid is high.
- The x-state of in_data is don't-care when in_valid = 0. Slots load only on a transfer.

Decomposition:
- Package demux_pkg:
  - function clog2_min1(n), returning clog2 with a minimum of 1.
  - localparams for the default widths.
- Sub-module demux_out_slot (parameter DATA_W):
  - one-entry register with load, data_in, y_valid, y_ready, y_data and a free output.
  - instantiated NUM_OUT times by generate.
- Top level contains only:
  - the select decode (one-hot load vector, or all-ones when broadcasting),
  - the in_ready reduction,
  - the range check,
  - the drop counter.

Test Plan:
- Reset: assert rst mid-stream with channels 1 and 3 full -> y_valid = 0 and drop_cnt = 0 asynchronously. After release, in_data = 0xA5, sel = 2, in_valid -> y_valid = 4'b0100 and y_data[2] = 0xA5 one cycle later.
- Back-to-back: y_ready = 4'b1111, stream 0x01..0x08 to sel 0,1,2,3,0,1,2,3 -> in_ready stays 1 every cycle; each channel shows its beats in order with 1-cycle latency.
- Backpressure:
  - y_ready[1] = 0, send two beats to sel 1 -> second beat sees in_ready = 0 and is held; y_data[1] stays at the first value.
  - raise y_ready[1] -> second beat is accepted in that same cycle.
- Broadcast:
  - slot 3 full and stalled, bcast = 1, in_data = 0x3C -> in_ready = 0.
  - drain slot 3 -> beat accepted; all y_valid = 1111, all y_data = 0x3C.
- Out-of-range: NUM_OUT = 3, sel = 3, 300 beats -> no y_valid ever set; drop_cnt saturates at 255.
- Independence: fill all 4 slots, drain channels 0 and 2 in the same cycle as a new unicast beat to sel 0 -> slot 0 is reloaded, slot 2 is emptied, slots 1 and 3 are unchanged.
